// File: rtl/store_mem_writer.sv
// store_mem_writer
//   Execute-side store unit. Takes decoded store fields, forms the effective address
//   (rs1_data + sext(imm)) and issues byte-enabled word writes to the data memory with a
//   req/ack handshake. Only one store is in flight at a time.
//
//   Build option: define STORE_SPLIT_EN to split misaligned SH/SW into two word beats.
//   Without it, a misaligned SH/SW is rejected with st_fault, cause 01.
//
// Ports
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   st_valid / st_ready         command handshake
//   store_control               SB / SH / SW / STR_NOP encoding
//   rs1_data, rs2_data, imm     base, store data, signed 12-bit offset
//   mem_req / mem_ack           memory beat handshake; addr/wdata/be stable while mem_req
//   mem_addr, mem_wdata, mem_be word address, lane-aligned data, byte enables
//   st_done, st_fault           one-cycle completion / abort pulses
//   fault_cause, fault_addr     01 misaligned, 10 timeout; effective address of the store
`timescale 1ns/1ps

module store_mem_writer #(
  parameter int unsigned TIMEOUT_CYC = 255  // req cycles per beat before abort; 0 = wait forever
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  store_control,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [11:0] imm,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        st_done,
  output logic        st_fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  // Store encodings shared with the decoder.
  localparam logic [2:0] STR_NOP = 3'b000;
  localparam logic [2:0] SB      = 3'b001;
  localparam logic [2:0] SH      = 3'b010;
  localparam logic [2:0] SW      = 3'b011;

`ifdef STORE_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] ea;
  logic [1:0]  off;
  logic [3:0]  mask;
  logic        is_store;
  logic        aligned;
  logic        tmo;
  logic [3:0]  lo_be, hi_be, hi_be_q;
  logic [31:0] lo_data, hi_data, hi_data_q;
  logic [31:0] cnt_q;
  logic        split_q;
  logic        fault_q;

  assign ea  = rs1_data + {{20{imm[11]}}, imm};
  assign off = ea[1:0];

  always_comb begin
    mask    = 4'b0000;
    aligned = 1'b1;
    case (store_control)
      SB:      mask = 4'b0001;
      SH: begin
        mask    = 4'b0011;
        aligned = (off != 2'd3);
      end
      SW: begin
        mask    = 4'b1111;
        aligned = (off == 2'd0);
      end
      STR_NOP: mask = 4'b0000;
      default: mask = 4'b0000;
    endcase
  end

  assign is_store = (mask != 4'b0000);

  // Lane placement: the low word is beat0, anything shifted past lane 3 spills into beat1.
`ifdef STORE_SPLIT_EN
  logic [7:0]  be_wide;
  logic [63:0] data_wide;
  assign be_wide   = {4'b0000, mask} << off;
  assign data_wide = {32'h0, rs2_data} << {off, 3'b000};
  assign lo_be     = be_wide[3:0];
  assign hi_be     = be_wide[7:4];
  assign lo_data   = data_wide[31:0];
  assign hi_data   = data_wide[63:32];
`else
  assign lo_be     = mask << off;
  assign lo_data   = rs2_data << {off, 3'b000};
  assign hi_be     = 4'b0000;
  assign hi_data   = 32'h0;
`endif

  // Ack in the last allowed cycle still wins over the timeout.
  assign tmo = (TIMEOUT_CYC != 0) && (cnt_q == TIMEOUT_CYC - 1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (st_valid) begin
          if (!is_store)                  state_d = RESP;
          else if (aligned || SPLIT_EN)   state_d = BEAT0;
          else                            state_d = RESP;
        end
      end
      BEAT0: begin
        if (mem_ack)  state_d = split_q ? BEAT1 : RESP;
        else if (tmo) state_d = RESP;
      end
      BEAT1: begin
        if (mem_ack || tmo) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    st_ready = (state_q == IDLE);
    mem_req  = (state_q == BEAT0) || (state_q == BEAT1);
    st_done  = (state_q == RESP) && !fault_q;
    st_fault = (state_q == RESP) && fault_q;
  end

  // Beat datapath, per-beat wait counter and fault capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_be      <= 4'b0000;
      hi_be_q     <= 4'b0000;
      hi_data_q   <= 32'h0;
      cnt_q       <= 32'h0;
      split_q     <= 1'b0;
      fault_q     <= 1'b0;
      fault_cause <= 2'b00;
      fault_addr  <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (st_valid) begin
            mem_addr    <= {ea[31:2], 2'b00};
            mem_be      <= lo_be;
            mem_wdata   <= lo_data;
            hi_be_q     <= hi_be;
            hi_data_q   <= hi_data;
            cnt_q       <= 32'h0;
            split_q     <= SPLIT_EN && is_store && !aligned;
            fault_q     <= !SPLIT_EN && is_store && !aligned;
            fault_cause <= (!SPLIT_EN && is_store && !aligned) ? 2'b01 : 2'b00;
            fault_addr  <= ea;
          end
        end
        BEAT0, BEAT1: begin
          if (mem_ack) begin
            cnt_q <= 32'h0;
            if (state_q == BEAT0 && split_q) begin
              mem_addr  <= mem_addr + 32'd4;  // wraps at the top of the address space
              mem_be    <= hi_be_q;
              mem_wdata <= hi_data_q;
            end
          end else if (tmo) begin
            fault_q     <= 1'b1;
            fault_cause <= 2'b10;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
